bcd_to_bin_seq: RTL
===================

// Module: bcd_to_bin_seq
// PURPOSE
//  Sequential BCD-to-binary decoder, reverse double-dabble (shift right, then subtract 3 from digits >= 8).
//  Sits downstream of the BCD digit adders and converts their DIGITS-digit packed BCD result to plain binary.
//  Typical consumers are binary datapaths and comparators.
//  Valid/ready on both sides; one bit decoded per clock; rejects non-decimal digits.
// PARAMETERS
//  DIGITS   2   number of BCD digits in in_bcd; also sets W = 4*DIGITS (in/out width and step count)
// PORTS
//  clk        in   1    clock; all state updates on rising edge
//  rst        in   1    reset, synchronous, active-high
//  in_valid   in   1    in_bcd holds a word to convert
//  in_ready   out  1    block idle, will accept on this edge
//  in_bcd     in   W    packed BCD; digit k = in_bcd[4k+3:4k], digit 0 least significant
//  out_valid  out  1    out_bin/out_err valid
//  out_ready  in   1    consumer takes result on this edge
//  out_bin    out  W    binary value of in_bcd (bits above ceil(log2(10^DIGITS)) always 0)
//  out_err    out  1    input had a digit > 9; out_bin forced to 0
// BEHAVIOUR
//  Reset: state IDLE; in_ready=1, out_valid=0, out_bin=0, out_err=0; internal regs cleared.
//  Reset mid-operation: conversion aborted, result discarded, no out_valid for it.
//  FSM IDLE -> SHIFT -> DONE -> IDLE; in_ready = (state==IDLE); out_valid = (state==DONE).
//  IDLE: on in_valid: check all digits.
//   - Any digit > 9: out_bin<=0, out_err<=1, go DONE directly.
//   - Otherwise: bcd_reg<=in_bcd, bin_reg<=0, cnt<=0, out_err<=0, go SHIFT.
//  SHIFT, one step per edge:
//   - {bcd_reg,bin_reg} shifted right 1; bcd_reg LSB enters bin_reg MSB, 0 enters bcd_reg MSB.
//   - Then every digit of the shifted bcd_reg that is >= 8 has 3 subtracted (4-bit, no borrow between digits).
//   - cnt increments; on step W (cnt==W-1) load out_bin<=shifted bin_reg and go DONE.
//  Latency, valid input: out_valid first high after exactly W+1 edges counted from the accepting edge (DIGITS=2: 9).
//  Latency, invalid input: out_valid first high after exactly 1 edge counted from the accepting edge.
//  DONE: out_bin/out_err held stable while out_ready=0 (unbounded backpressure); on out_ready go IDLE.
//  No bypass: in_ready is 0 in the DONE cycle even if out_ready=1.
//  Throughput is one word per W+2 cycles minimum.
//  in_bcd sampled only on the accepting edge; later changes ignored.
//  in_valid while not in_ready: no effect, word not consumed.
//  Result width: 10^DIGITS-1 < 2^W, so out_bin never overflows; no wrap-around possible.
//  All-zero input is a normal conversion with full W+1 latency, out_bin=0, out_err=0.
// TESTING (DIGITS=2 unless noted)
//  in_bcd=8'h99 accepted, out_ready=1 -> out_valid after 9 edges, out_bin=8'h63 (99), out_err=0, then in_ready=1
//  in_bcd=8'h00 and 8'h59 back-to-back -> out_bin 8'h00 then 8'h3B (59); second accepted only after first handed off
//  in_bcd=8'h3A -> out_valid after 1 edge, out_err=1, out_bin=0; in_bcd=8'hF0 -> same error response
//  in_bcd=8'h47, out_ready=0 for 20 cycles -> out_valid, out_bin=8'h2F held constant, in_ready=0 throughout
//  rst=1 at step 4 of in_bcd=8'h88 -> next cycle in_ready=1, out_valid=0; then in_bcd=8'h12 -> out_bin=8'h0C
//  DIGITS=3, exhaustive 000..999 with random in_valid/out_ready gaps -> out_bin equals decimal value, latency 13

Source files
------------

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter using reverse double-dabble.
// One result bit is produced per clock; words with a non-decimal digit are flagged in one cycle.
module bcd_to_bin_seq #(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_bcd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bin,
    output logic                  out_err
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [W-1:0]    bcd_reg;
    logic [W-1:0]    bin_reg;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    sh_bcd;
    logic [W-1:0]    sh_bin;
    logic [W-1:0]    adj_bcd;
    logic            bad_digit;
    logic            last_step;

    // One reverse-dabble step: shift right, then pull every digit that now reads >= 8 back by 3.
    always_comb begin
        sh_bcd  = {1'b0, bcd_reg[W-1:1]};
        sh_bin  = {bcd_reg[0], bin_reg[W-1:1]};
        adj_bcd = sh_bcd;
        for (int k = 0; k < DIGITS; k++) begin
            if (sh_bcd[4*k+3]) begin
                adj_bcd[4*k +: 4] = sh_bcd[4*k +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        bad_digit = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (in_bcd[4*k +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    assign last_step = (cnt == CW'(W - 1));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = bad_digit ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers; the result is only written when the last step completes or on a rejected word.
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_reg <= '0;
            bin_reg <= '0;
            cnt     <= '0;
            out_bin <= '0;
            out_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (bad_digit) begin
                            out_bin <= '0;
                            out_err <= 1'b1;
                        end else begin
                            bcd_reg <= in_bcd;
                            bin_reg <= '0;
                            cnt     <= '0;
                            out_err <= 1'b0;
                        end
                    end
                end
                SHIFT: begin
                    bcd_reg <= adj_bcd;
                    bin_reg <= sh_bin;
                    cnt     <= cnt + 1'b1;
                    if (last_step) begin
                        out_bin <= sh_bin;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
